// File: rtl/vga_mode_sequencer.sv
// ============================================================================
//  Module      : vga_mode_sequencer
//  Description : N-way display-mode selector between the VGA timing core and
//                the pins. It steps a requested mode forward/backward from
//                key ticks and commits the switch only at the start of
//                vertical blanking. It can force black for a programmable
//                number of frames after a switch. Colour and syncs leave
//                through one register stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_mode_sequencer #(
    parameter int NUM_MODES    = 4,
    parameter int MODE_W       = 2,
    parameter int DEFAULT_MODE = 0,
    parameter int BLANK_FRAMES = 1,
    parameter int V_ACTIVE     = 480,
    parameter int R_W          = 5,
    parameter int G_W          = 6,
    parameter int B_W          = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [11:0]            pixel_x,
    input  logic [11:0]            pixel_y,
    input  logic                   video_on,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [3*NUM_MODES-1:0] rgb_in,
    input  logic                   mode_next,
    input  logic                   mode_prev,
    output logic [R_W-1:0]         vga_out_r,
    output logic [G_W-1:0]         vga_out_g,
    output logic [B_W-1:0]         vga_out_b,
    output logic                   vga_out_hs,
    output logic                   vga_out_vs,
    output logic [MODE_W-1:0]      mode,
    output logic                   busy
);

    // Reject configurations that could select a non-existent renderer.
    generate
        if (NUM_MODES < 2 || NUM_MODES > 16 ||
            DEFAULT_MODE < 0 || DEFAULT_MODE >= NUM_MODES ||
            MODE_W < $clog2(NUM_MODES) ||
            BLANK_FRAMES < 0 || BLANK_FRAMES > 15) begin : g_param_check
            $error("vga_mode_sequencer: illegal parameter combination");
        end
    endgenerate

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_BLANK   = 2'd2;

    localparam logic [MODE_W-1:0] MODE_LAST  = MODE_W'(NUM_MODES - 1);
    localparam logic [MODE_W-1:0] MODE_ONE   = MODE_W'(1);
    localparam logic [MODE_W-1:0] MODE_RST   = MODE_W'(DEFAULT_MODE);
    localparam logic [3:0]        BLANK_INIT = 4'(BLANK_FRAMES);

    logic [1:0]        state;
    logic [MODE_W-1:0] target;
    logic [3:0]        blank_cnt;

    logic              req_next;
    logic              req_prev;
    logic [MODE_W-1:0] target_upd;
    logic              at_boundary;
    logic [2:0]        sel_rgb;
    logic              force_black;

    // Next requested index: simultaneous next+prev cancel each other out.
    always_comb begin
        req_next   = mode_next & ~mode_prev;
        req_prev   = mode_prev & ~mode_next;
        target_upd = target;
        if (req_next) begin
            target_upd = (target == MODE_LAST) ? '0 : target + MODE_ONE;
        end else if (req_prev) begin
            target_upd = (target == '0) ? MODE_LAST : target - MODE_ONE;
        end
    end

    assign at_boundary = (pixel_y == 12'(V_ACTIVE)) && (pixel_x == 12'd0);

    // Mode state machine; the request of this cycle is folded in before any
    // commit so a tick landing on the boundary is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            mode      <= MODE_RST;
            target    <= MODE_RST;
            blank_cnt <= 4'd0;
        end else begin
            target <= target_upd;
            case (state)
                ST_RUN: begin
                    if (target_upd != mode) begin
                        state <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (target_upd == mode) begin
                        state <= ST_RUN;
                    end else if (at_boundary) begin
                        mode      <= target_upd;
                        blank_cnt <= BLANK_INIT;
                        state     <= (BLANK_INIT != 4'd0) ? ST_BLANK : ST_RUN;
                    end
                end
                ST_BLANK: begin
                    // Exiting blank never commits; a pending switch waits
                    // for the following boundary.
                    if (at_boundary) begin
                        blank_cnt <= blank_cnt - 4'd1;
                        if (blank_cnt <= 4'd1) begin
                            state <= (target_upd != mode) ? ST_PENDING : ST_RUN;
                        end
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Renderer select driven by the committed mode only.
    always_comb begin
        sel_rgb = 3'b000;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (mode == MODE_W'(k)) begin
                sel_rgb = rgb_in[3*k +: 3];
            end
        end
    end

    assign force_black = !video_on || (state == ST_BLANK);

    // Single output stage keeps colour and syncs aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_out_r  <= '0;
            vga_out_g  <= '0;
            vga_out_b  <= '0;
            vga_out_hs <= 1'b1;
            vga_out_vs <= 1'b1;
        end else begin
            vga_out_r  <= force_black ? '0 : {R_W{sel_rgb[2]}};
            vga_out_g  <= force_black ? '0 : {G_W{sel_rgb[1]}};
            vga_out_b  <= force_black ? '0 : {B_W{sel_rgb[0]}};
            vga_out_hs <= hsync_in;
            vga_out_vs <= vsync_in;
        end
    end

    assign busy = (state != ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_vga_mode_sequencer.sv
// ============================================================================
//  Module      : tb_vga_mode_sequencer
//  Description : Directed bench for vga_mode_sequencer using a miniature
//                10x9 raster (8x6 visible). Instance a: DEFAULT_MODE=2,
//                BLANK_FRAMES=0. Instance b: DEFAULT_MODE=0, BLANK_FRAMES=2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_mode_sequencer;

    logic        clk;
    logic        rst_n;
    logic [11:0] px = 12'd0;
    logic [11:0] py = 12'd0;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic [11:0] rgb_in;
    logic        next_a = 1'b0, prev_a = 1'b0, next_b = 1'b0, prev_b = 1'b0;

    logic [4:0]  r_a, b_a, r_b, b_b;
    logic [5:0]  g_a, g_b;
    logic        hs_a, vs_a, hs_b, vs_b;
    logic [1:0]  mode_a, mode_b;
    logic        busy_a, busy_b;
    logic [15:0] col_a, col_b;

    int total = 0;
    int bad   = 0;

    // mode0 red, mode1 green, mode2 blue, mode3 white
    assign rgb_in   = {3'b111, 3'b001, 3'b010, 3'b100};
    assign video_on = (px < 12'd8) && (py < 12'd6);
    assign hsync_in = (px != 12'd9);
    assign vsync_in = (py != 12'd7);
    assign col_a    = {r_a, g_a, b_a};
    assign col_b    = {r_b, g_b, b_b};

    vga_mode_sequencer #(
        .NUM_MODES(4), .MODE_W(2), .DEFAULT_MODE(2), .BLANK_FRAMES(0),
        .V_ACTIVE(6), .R_W(5), .G_W(6), .B_W(5)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .pixel_x(px), .pixel_y(py),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .mode_next(next_a), .mode_prev(prev_a),
        .vga_out_r(r_a), .vga_out_g(g_a), .vga_out_b(b_a),
        .vga_out_hs(hs_a), .vga_out_vs(vs_a), .mode(mode_a), .busy(busy_a)
    );

    vga_mode_sequencer #(
        .NUM_MODES(4), .MODE_W(2), .DEFAULT_MODE(0), .BLANK_FRAMES(2),
        .V_ACTIVE(6), .R_W(5), .G_W(6), .B_W(5)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .pixel_x(px), .pixel_y(py),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .mode_next(next_b), .mode_prev(prev_b),
        .vga_out_r(r_b), .vga_out_g(g_b), .vga_out_b(b_b),
        .vga_out_hs(hs_b), .vga_out_vs(vs_b), .mode(mode_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running raster counters, independent of the DUT reset.
    always @(posedge clk) begin
        if (px == 12'd9) begin
            px <= 12'd0;
            py <= (py == 12'd8) ? 12'd0 : py + 12'd1;
        end else begin
            px <= px + 12'd1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to the falling edge where pixel (x,y) is presented.
    task automatic wait_pix(input int x, input int y);
        int n;
        n = 0;
        @(negedge clk);
        while (!(px == 12'(x) && py == 12'(y)) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_pix", {31'd0, (px == 12'(x) && py == 12'(y))}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_mode_a", mode_a, 2);
        check_val("rst_mode_b", mode_b, 0);
        check_val("rst_col_a", col_a, 0);
        check_val("rst_sync_a", {hs_a, vs_a}, 2'b11);
        check_val("rst_busy", {busy_a, busy_b}, 0);
        rst_n = 1'b1;

        // colour appears one clock after video_on
        wait_pix(0, 0);
        check_val("pre_video_a", col_a, 0);
        @(negedge clk);
        check_val("first_pix_a", col_a, 16'h001F);
        check_val("first_pix_b", col_b, 16'hF800);

        // deferred switch on a: 2 -> 3
        wait_pix(3, 2);
        next_a = 1'b1;
        @(negedge clk);
        next_a = 1'b0;
        check_val("defer_busy", busy_a, 1);
        check_val("defer_mode_hold", mode_a, 2);
        wait_pix(9, 2);
        check_val("hs_high", hs_a, 1);
        @(negedge clk);
        check_val("hs_low_aligned", hs_a, 0);
        wait_pix(7, 5);
        @(negedge clk);
        check_val("defer_last_pix", col_a, 16'h001F);
        wait_pix(0, 6);
        check_val("defer_pre_bnd", mode_a, 2);
        @(negedge clk);
        check_val("defer_commit", mode_a, 3);
        check_val("defer_busy_fall", busy_a, 0);
        wait_pix(0, 0);
        @(negedge clk);
        check_val("defer_new_col", col_a, 16'hFFFF);

        // wrap on a (3 -> 0) and wrap/cancel on b
        next_a = 1'b1; prev_b = 1'b1;
        @(negedge clk);
        next_a = 1'b0; prev_b = 1'b0;
        check_val("wrap_busy_a", busy_a, 1);
        check_val("wrap_busy_b", busy_b, 1);
        next_b = 1'b1; prev_b = 1'b1;
        @(negedge clk);
        next_b = 1'b0; prev_b = 1'b0;
        check_val("both_nochange", busy_b, 1);
        next_b = 1'b1;
        @(negedge clk);
        next_b = 1'b0;
        check_val("cancel_busy", busy_b, 0);
        wait_pix(0, 6);
        @(negedge clk);
        check_val("wrap_fwd_commit", mode_a, 0);
        check_val("cancel_no_switch", mode_b, 0);
        check_val("cancel_busy_bnd", busy_b, 0);

        // blank frames on b: 0 -> 1
        wait_pix(2, 1);
        next_b = 1'b1;
        @(negedge clk);
        next_b = 1'b0;
        check_val("blank_req_busy", busy_b, 1);
        wait_pix(0, 6);
        @(negedge clk);
        check_val("blank_commit", mode_b, 1);
        check_val("blank_busy1", busy_b, 1);
        wait_pix(0, 0);
        @(negedge clk);
        check_val("blank_f1_first", col_b, 0);
        wait_pix(4, 3);
        @(negedge clk);
        check_val("blank_f1_mid", col_b, 0);
        wait_pix(0, 6);
        @(negedge clk);
        check_val("blank_busy2", busy_b, 1);
        wait_pix(4, 3);
        @(negedge clk);
        check_val("blank_f2_mid", col_b, 0);
        wait_pix(0, 6);
        check_val("blank_busy_last", busy_b, 1);
        @(negedge clk);
        check_val("blank_busy_fall", busy_b, 0);
        wait_pix(0, 0);
        @(negedge clk);
        check_val("blank_f3_col", col_b, 16'h07E0);

        // request during blank on b: 1 -> 2, then 3 requested while blanked
        next_b = 1'b1;
        @(negedge clk);
        next_b = 1'b0;
        wait_pix(0, 6);
        @(negedge clk);
        check_val("rdb_commit2", mode_b, 2);
        wait_pix(3, 2);
        next_b = 1'b1;
        @(negedge clk);
        next_b = 1'b0;
        wait_pix(0, 6);
        @(negedge clk);
        check_val("rdb_mid_mode", mode_b, 2);
        wait_pix(0, 6);
        @(negedge clk);
        check_val("rdb_exit_nocommit", mode_b, 2);
        check_val("rdb_exit_busy", busy_b, 1);
        wait_pix(0, 0);
        @(negedge clk);
        check_val("rdb_pending_col", col_b, 16'h001F);
        wait_pix(0, 6);
        @(negedge clk);
        check_val("rdb_commit3", mode_b, 3);

        // boundary collision on a: target 1, tick on boundary -> 2
        wait_pix(2, 1);
        next_a = 1'b1;
        @(negedge clk);
        next_a = 1'b0;
        wait_pix(0, 6);
        next_a = 1'b1;
        @(negedge clk);
        next_a = 1'b0;
        check_val("collide_mode", mode_a, 2);
        check_val("collide_busy", busy_a, 0);

        // asynchronous reset mid-line
        wait_pix(3, 2);
        next_a = 1'b1;
        @(negedge clk);
        next_a = 1'b0;
        check_val("prerst_busy", busy_a, 1);
        check_val("prerst_col", col_a, 16'h001F);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_mode_a", mode_a, 2);
        check_val("arst_busy_a", busy_a, 0);
        check_val("arst_col_a", col_a, 0);
        check_val("arst_sync_a", {hs_a, vs_a}, 2'b11);
        check_val("arst_mode_b", mode_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_pix(0, 6);
        @(negedge clk);
        check_val("post_rst_mode_a", mode_a, 2);
        check_val("post_rst_busy_a", busy_a, 0);
        wait_pix(0, 0);
        @(negedge clk);
        check_val("post_rst_col_a", col_a, 16'h001F);
        check_val("post_rst_col_b", col_b, 16'hF800);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vga_mode_sequencer.md
# vga_mode_sequencer

Parametrised N-way display-mode selector between the VGA timing core and the VGA pins. It takes 3-bit RGB from `NUM_MODES` text/graphics renderers and selects one for display. It cycles the selection forward/backward from debounced key ticks and commits a switch only at the start of vertical blanking, so no frame tears. It can blank a programmable number of frames after each switch and registers all pin outputs in one pipeline stage.

## Interface
Parameters:
- `NUM_MODES`, 4 — number of renderer inputs; 2..16.
- `MODE_W`, 2 — width of mode index; equals ceil(log2(NUM_MODES)).
- `DEFAULT_MODE`, 0 — mode selected after reset.
- `BLANK_FRAMES`, 1 — whole frames forced black after a committed switch; 0..15.
- `V_ACTIVE`, 480 — first non-visible line; the frame boundary is `pixel_y==V_ACTIVE && pixel_x==0`.
- `R_W`, 5; `G_W`, 6; `B_W`, 5 — pin widths for red, green and blue.

Ports:
- `clk` in 1 — pixel clock (25 MHz for 640x480). One clock domain.
- `rst_n` in 1 — asynchronous, active-low reset.
- `pixel_x`, `pixel_y` in 12 each — current pixel coordinates from `vga_core`.
- `video_on` in 1 — active-area flag.
- `hsync_in`, `vsync_in` in 1 each — sync signals from `vga_core`.
- `rgb_in` in 3*NUM_MODES — mode k occupies bits [3k+2:3k], ordered {r,g,b}.
- `mode_next`, `mode_prev` in 1 each — single-cycle request ticks (debounced upstream).
- `vga_out_r` out R_W; `vga_out_g` out G_W; `vga_out_b` out B_W — pixel colour outputs.
- `vga_out_hs`, `vga_out_vs` out 1 each — sync outputs.
- `mode` out MODE_W — committed mode index.
- `busy` out 1 — high in PENDING or BLANK.

## Operation
- Registers:
  - `mode`: committed index.
  - `target`: requested index.
  - 4-bit `blank_cnt`.
  - 2-bit state.
- Request arithmetic is applied to `target`:
  - `mode_next` gives target+1; NUM_MODES-1 wraps to 0.
  - `mode_prev` gives target-1; 0 wraps to NUM_MODES-1.
  - Both asserted in the same cycle: no change.
- State machine:
  - **RUN** — `target==mode`. A request updates `target`. If the new target differs from `mode`, go to PENDING.
  - **PENDING** — further requests keep updating `target`.
    - If `target` returns to `mode`, go back to RUN without a switch.
    - At the frame boundary: `mode<=target`, `blank_cnt<=BLANK_FRAMES`. Next state is BLANK if BLANK_FRAMES>0, else RUN.
    - If a request and the boundary occur in the same cycle, the request is applied first and the updated target is committed.
  - **BLANK** — colour is forced black. Requests update `target` only.
    - Each frame boundary decrements `blank_cnt`.
    - When it reaches 0 on a boundary: go to PENDING if `target!=mode`, else RUN.
    - A new switch needs a further boundary, so it is never committed on the same boundary as the exit.
- Colour path:
  - Select `rgb_in[3*mode +: 3]`.
  - Force 0 when `!video_on` or in BLANK.
  - Expand each bit to all-ones or all-zeros at its pin width.
- `DEFAULT_MODE>=NUM_MODES` or `MODE_W` too narrow is an elaboration error.
- Reset mid-operation clears all state immediately: `mode=target=DEFAULT_MODE`, RUN, `blank_cnt=0`.

## Timing
- Reset values:
  - Colour outputs 0.
  - `vga_out_hs=1`, `vga_out_vs=1`.
  - `mode=DEFAULT_MODE`, `busy=0`.
- Latency and alignment:
  - Colour, hs and vs are registered in one stage, so all are exactly 1 clk after inputs. Sync-to-colour alignment is preserved.
  - `rgb_in` must be valid for the same cycle's `pixel_x`/`pixel_y`.
- Commit timing:
  - `mode` changes on the clk edge where the boundary is sampled.
  - The first pixel of the new mode is pixel (0,0) of the next frame, or of frame BLANK_FRAMES+1 after the switch when blanking is enabled.
- `busy` is registered from the state: it rises 1 clk after the causing request and falls 1 clk after the exit boundary.
- Ticks arriving faster than 1 per clk are not supported. Every tick is counted.

## Test plan
- **Reset:** NUM_MODES=4, DEFAULT_MODE=2, assert rst_n=0 mid-line. Required: colour 0, hs/vs=1, mode=2 immediately. After release, mode-2 colour appears 1 clk after video_on.
- **Deferred switch:** BLANK_FRAMES=0, mode_next at y=100. Required: mode stays 0 through y=479. mode=1 at (0,480); frame N+1 shows mode-1 colour from (0,0).
- **Wrap and cancel:** one mode_prev from mode 0 gives target 3. Then mode_next+mode_prev together gives no change. Then mode_next returns target to 0 with busy=0 and no switch at the boundary.
- **Blank frames:** BLANK_FRAMES=2, switch 0→1. Required: the next 2 whole frames output 0 during video_on, the 3rd shows mode 1, and busy spans exactly those frames.
- **Request during BLANK:** mode_next issued during BLANK. Required: it commits mode 2 at the boundary after blanking ends, not the same boundary.
- **Boundary collision:** mode_next in the exact boundary cycle while in PENDING with target=1. Required: mode=2 committed.
